outputc: RTL and testbench
==========================

// Module: outputc
// PURPOSE
//  Output physical-channel stage of the router; one instance per output port, downstream of the five inputc blocks.
//  - Arbitrates flit-level among inputc requests targeting this port and returns grt_*.
//  - Registers the granted flit onto the link.
//  - Tracks per-output-VC packet locks (olck) and forwards downstream VC readiness (ordy), which every inputc samples as irdy_<PCHID>/ilck_<PCHID>.
// PARAMETERS
//  PCHID   0   physical channel id of this output port (0..4); a request counts only when port_i == PCHID
// PORTS
//  clk        in   1          clock
//  rst_       in   1          reset, asynchronous, active-low; one clock domain
//  idata_i    in   DATAW+1    flit from inputc i (i=0..4)
//  ivalid_i   in   1          flit valid from inputc i (i=0..4)
//  ivch_i     in   VCHW+1     output VC chosen by inputc i (i=0..4)
//  req_i      in   1          switch request from inputc i (i=0..4)
//  port_i     in   PORTW+1    requested output port of inputc i (i=0..4)
//  grt_i      out  1          grant to inputc i, this cycle (i=0..4)
//  irdy       in   VCH+1      per-VC ready from the downstream router's input buffers
//  ilck       in   VCH+1      per-VC lock from the downstream router (monitor only, not used in arbitration)
//  odata      out  DATAW+1    link flit
//  ovalid     out  1          link flit valid
//  ovch       out  VCHW+1     link flit VC
//  ordy       out  VCH+1      = irdy, combinational pass-through
//  olck       out  VCH+1      per-VC packet-in-progress lock
//  err        out  1          sticky protocol error
// BEHAVIOUR
//  - Reset (async, rst_=0): ptr=0, olck=0, odata=0, ovalid=0, ovch=0, err=0. grt_* are 0 while in reset.
//    Asserting rst_ mid-packet drops all locks; no flit is emitted until a new grant.
//  - Effective request: r_i = req_i && (port_i == PCHID).
//  - Arbiter: round-robin over r_0..r_4, searching from ptr upward with wrap 4->0.
//    - At most one grt_i per cycle, combinational (same cycle as req).
//    - On any grant to i, ptr <= (i==4) ? 0 : i+1.
//    - No request: no grant, ptr holds.
//  - Flit capture: at a cycle with grt_i && ivalid_i && type != TYPE_NONE, the next edge loads:
//    odata <= idata_i, ovch <= ivch_i, ovalid <= 1.
//    Otherwise ovalid <= 0 and odata <= 0. Latency is 1 cycle from grant to link.
//    ivalid_j from a non-granted j is ignored.
//  - Flit type = idata[TYPE_MSB:TYPE_LSB].
//  - Locks, for a captured flit on VC v:
//    - HEAD: olck[v] <= 1.
//    - TAIL: olck[v] <= 0.
//    - HEADTAIL: olck[v] unchanged (stays 0).
//    - DATA: no change.
//  - err <= 1 (sticky until reset) when any of these occurs on a captured flit:
//    - HEAD or HEADTAIL arrives on a VC with olck[v]=1;
//    - DATA or TAIL arrives on a VC with olck[v]=0;
//    - ivch >= VCH+1.
//    The flit is still forwarded.
//  - ordy = irdy (no register, so inputc credit checks see current downstream state).
//    ilck is not used in arbitration.
//  - Widths: ptr is 3 bits and holds only 0..4. Port compare is PORTW+1 bits, zero-extended PCHID.
// STRUCTURE
//  - Shared constants (DATAW, VCH, VCHW, PORTW, TYPE_*, TYPE_MSB/LSB, Enable/Disable) come from define.h; nothing new is added.
//  - One sub-module: rr_arb5 (5-way round-robin arbiter: req[4:0] in, grt[4:0] out, ptr state inside).
//    outputc holds the flit mux, output registers, lock vector and error logic.
// TESTING
//  1. Reset: rst_=0 mid-traffic -> all outputs 0 immediately; after release, first grant to the lowest requester >= 0.
//  2. Single packet: inputc2 req, port=PCHID, HEAD/DATA/TAIL on vch 1 over 3 cycles -> grt_2 each cycle;
//     odata follows 1 cycle later; olck=2'b10 from the cycle after HEAD until the cycle after TAIL.
//  3. Round-robin: r_0, r_1 and r_4 held high -> grants 0,1,4,0,1,4...; then only r_4 -> grt_4 every cycle, ptr wraps to 0.
//  4. Port filter: req_3=1 with port_3 != PCHID -> grt_3=0, ovalid=0.
//  5. HEADTAIL on vch 0 -> ovalid pulse for 1 cycle, olck stays 0, err=0.
//  6. Protocol error: DATA on an unlocked VC -> flit forwarded, err=1 and held until reset.
//  Credit pass-through: irdy=2'b01 -> ordy=2'b01 in the same cycle.

Source files
------------

// File: rtl/outputc_pkg.sv
// Shared router constants and flit-type helpers used by the output channel stage.
`default_nettype none

package outputc_pkg;

    localparam int DATAW    = 31;
    localparam int VCH      = 1;
    localparam int VCHW     = 1;
    localparam int PORTW    = 2;
    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 29;
    localparam int NPORT    = 5;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    typedef enum logic [2:0] {
        TYPE_NONE     = 3'd0,
        TYPE_HEAD     = 3'd1,
        TYPE_TAIL     = 3'd2,
        TYPE_HEADTAIL = 3'd3,
        TYPE_DATA     = 3'd4
    } flit_type_e;

    function automatic flit_type_e flit_type(input logic [DATAW:0] d);
        return flit_type_e'(d[TYPE_MSB:TYPE_LSB]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/outputc_rr_arb5.sv
// Five-way round-robin arbiter; the search starts at the pointer and wraps 4 -> 0.
`default_nettype none

module rr_arb5
    import outputc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_,
    input  logic [4:0] req_i,
    output logic [4:0] grt_o
);

    logic [2:0] ptr_q;
    logic [2:0] ptr_d;
    logic [2:0] idx;
    logic [3:0] sum;
    logic       found;

    always_comb begin
        grt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = 0; k < NPORT; k++) begin
            sum = {1'b0, ptr_q} + 4'(k);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                grt_o[idx] = 1'b1;
                ptr_d      = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            end
        end
        // Grants must stay low while reset is held, even with live requests.
        if (!rst_) begin
            grt_o = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/outputc.sv
// Output physical-channel stage: arbitrates inputc requests, registers the granted
// flit onto the link, tracks per-VC packet locks and flags protocol errors.
`default_nettype none

module outputc
    import outputc_pkg::*;
#(
    parameter int PCHID = 0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW:0]   idata_0,
    input  logic [DATAW:0]   idata_1,
    input  logic [DATAW:0]   idata_2,
    input  logic [DATAW:0]   idata_3,
    input  logic [DATAW:0]   idata_4,
    input  logic             ivalid_0,
    input  logic             ivalid_1,
    input  logic             ivalid_2,
    input  logic             ivalid_3,
    input  logic             ivalid_4,
    input  logic [VCHW:0]    ivch_0,
    input  logic [VCHW:0]    ivch_1,
    input  logic [VCHW:0]    ivch_2,
    input  logic [VCHW:0]    ivch_3,
    input  logic [VCHW:0]    ivch_4,
    input  logic             req_0,
    input  logic             req_1,
    input  logic             req_2,
    input  logic             req_3,
    input  logic             req_4,
    input  logic [PORTW:0]   port_0,
    input  logic [PORTW:0]   port_1,
    input  logic [PORTW:0]   port_2,
    input  logic [PORTW:0]   port_3,
    input  logic [PORTW:0]   port_4,
    output logic             grt_0,
    output logic             grt_1,
    output logic             grt_2,
    output logic             grt_3,
    output logic             grt_4,
    input  logic [VCH:0]     irdy,
    input  logic [VCH:0]     ilck,
    output logic [DATAW:0]   odata,
    output logic             ovalid,
    output logic [VCHW:0]    ovch,
    output logic [VCH:0]     ordy,
    output logic [VCH:0]     olck,
    output logic             err
);

    localparam logic [PORTW:0] PCH_SEL = (PORTW + 1)'(PCHID);

    logic [DATAW:0] data_a [NPORT];
    logic [VCHW:0]  vch_a  [NPORT];
    logic [4:0]     valid_a;
    logic [4:0]     req_eff;
    logic [4:0]     grt;

    assign data_a  = '{idata_0, idata_1, idata_2, idata_3, idata_4};
    assign vch_a   = '{ivch_0, ivch_1, ivch_2, ivch_3, ivch_4};
    assign valid_a = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
    assign req_eff = {req_4 && (port_4 == PCH_SEL), req_3 && (port_3 == PCH_SEL),
                      req_2 && (port_2 == PCH_SEL), req_1 && (port_1 == PCH_SEL),
                      req_0 && (port_0 == PCH_SEL)};

    rr_arb5 u_arb (
        .clk   (clk),
        .rst_  (rst_),
        .req_i (req_eff),
        .grt_o (grt)
    );

    assign {grt_4, grt_3, grt_2, grt_1, grt_0} = grt;
    assign ordy = irdy;

    // Downstream lock state is observed only; it never steers arbitration.
    logic unused_ilck;
    assign unused_ilck = ^ilck;

    logic [DATAW:0] sel_data;
    logic [VCHW:0]  sel_vch;
    logic           sel_valid;
    logic           cap;
    logic           vch_ok;
    logic           lock_cur;
    flit_type_e     ftype;

    logic [DATAW:0] odata_q, odata_d;
    logic           ovalid_q, ovalid_d;
    logic [VCHW:0]  ovch_q, ovch_d;
    logic [VCH:0]   olck_q, olck_d;
    logic           err_q, err_d;

    always_comb begin
        sel_data  = '0;
        sel_vch   = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (grt[i]) begin
                sel_data  = data_a[i];
                sel_vch   = vch_a[i];
                sel_valid = valid_a[i];
            end
        end
    end

    assign ftype  = flit_type(sel_data);
    assign cap    = sel_valid && (ftype != TYPE_NONE);
    assign vch_ok = (sel_vch <= (VCHW + 1)'(VCH));

    always_comb begin
        odata_d  = '0;
        ovalid_d = 1'b0;
        ovch_d   = ovch_q;
        olck_d   = olck_q;
        err_d    = err_q;
        lock_cur = 1'b0;
        for (int v = 0; v <= VCH; v++) begin
            if (sel_vch == (VCHW + 1)'(v)) begin
                lock_cur = olck_q[v];
            end
        end
        if (cap) begin
            odata_d  = sel_data;
            ovalid_d = 1'b1;
            ovch_d   = sel_vch;
            case (ftype)
                TYPE_HEAD: begin
                    if (lock_cur) err_d = 1'b1;
                    for (int v = 0; v <= VCH; v++) begin
                        if (sel_vch == (VCHW + 1)'(v)) olck_d[v] = 1'b1;
                    end
                end
                TYPE_TAIL: begin
                    if (!lock_cur) err_d = 1'b1;
                    for (int v = 0; v <= VCH; v++) begin
                        if (sel_vch == (VCHW + 1)'(v)) olck_d[v] = 1'b0;
                    end
                end
                TYPE_HEADTAIL: if (lock_cur)  err_d = 1'b1;
                TYPE_DATA:     if (!lock_cur) err_d = 1'b1;
                default: ;
            endcase
            if (!vch_ok) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ovch_q   <= '0;
            olck_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ovch_q   <= ovch_d;
            olck_q   <= olck_d;
            err_q    <= err_d;
        end
    end

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign ovch   = ovch_q;
    assign olck   = olck_q;
    assign err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_outputc.sv
// Randomized and directed bench for outputc against a behavioural channel model.
`default_nettype none

module tb_outputc;
    import outputc_pkg::*;

    localparam int P = 2;

    logic             clk = 1'b0;
    logic             rst_ = 1'b1;
    logic [DATAW:0]   idata [5];
    logic [4:0]       ivalid;
    logic [VCHW:0]    ivch  [5];
    logic [4:0]       req;
    logic [PORTW:0]   port  [5];
    logic [VCH:0]     irdy, ilck;
    wire  [4:0]       grt;
    wire  [DATAW:0]   odata;
    wire              ovalid;
    wire  [VCHW:0]    ovch;
    wire  [VCH:0]     ordy, olck;
    wire              err;

    outputc #(.PCHID(P)) dut (
        .clk(clk), .rst_(rst_),
        .idata_0(idata[0]), .idata_1(idata[1]), .idata_2(idata[2]), .idata_3(idata[3]), .idata_4(idata[4]),
        .ivalid_0(ivalid[0]), .ivalid_1(ivalid[1]), .ivalid_2(ivalid[2]), .ivalid_3(ivalid[3]), .ivalid_4(ivalid[4]),
        .ivch_0(ivch[0]), .ivch_1(ivch[1]), .ivch_2(ivch[2]), .ivch_3(ivch[3]), .ivch_4(ivch[4]),
        .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]), .req_4(req[4]),
        .port_0(port[0]), .port_1(port[1]), .port_2(port[2]), .port_3(port[3]), .port_4(port[4]),
        .grt_0(grt[0]), .grt_1(grt[1]), .grt_2(grt[2]), .grt_3(grt[3]), .grt_4(grt[4]),
        .irdy(irdy), .ilck(ilck),
        .odata(odata), .ovalid(ovalid), .ovch(ovch), .ordy(ordy), .olck(olck), .err(err)
    );

    always #5 clk = ~clk;

    // Reference state of the output channel
    int             m_ptr;
    logic [DATAW:0] m_odata;
    logic           m_ovalid;
    logic [VCHW:0]  m_ovch;
    logic [VCH:0]   m_olck;
    logic           m_err;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int pick(input int ptr, input logic [4:0] r);
        for (int k = 0; k < 5; k++) begin
            if (r[(ptr + k) % 5]) return (ptr + k) % 5;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_odata = '0; m_ovalid = 1'b0; m_ovch = '0; m_olck = '0; m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_odata"},  64'(odata),  64'(m_odata));
        chk({tag, "_ovalid"}, 64'(ovalid), 64'(m_ovalid));
        chk({tag, "_ovch"},   64'(ovch),   64'(m_ovch));
        chk({tag, "_olck"},   64'(olck),   64'(m_olck));
        chk({tag, "_err"},    64'(err),    64'(m_err));
    endtask

    task automatic idle();
        for (int i = 0; i < 5; i++) begin
            idata[i] = '0; ivch[i] = '0; port[i] = '0;
        end
        ivalid = '0; req = '0;
    endtask

    task automatic put(input int i, input logic [2:0] t, input int v);
        logic [DATAW:0] d;
        d = DATAW'($urandom);
        d[TYPE_MSB:TYPE_LSB] = t;
        idata[i] = d; ivch[i] = (VCHW + 1)'(v); port[i] = (PORTW + 1)'(P);
        ivalid[i] = 1'b1; req[i] = 1'b1;
    endtask

    // Called at a falling edge with inputs already driven; ends at the next falling edge.
    task automatic cycle(input string tag);
        logic [4:0] r;
        int g, v;
        logic [2:0] t;
        logic locked;
        #1;
        for (int i = 0; i < 5; i++) r[i] = req[i] && (port[i] == (PORTW + 1)'(P));
        g = pick(m_ptr, r);
        chk({tag, "_grt"}, 64'(grt), (g < 0) ? 64'd0 : (64'd1 << g));
        chk({tag, "_ordy"}, 64'(ordy), 64'(irdy));
        m_ovalid = 1'b0;
        m_odata  = '0;
        if (g >= 0) begin
            m_ptr = (g + 1) % 5;
            t = idata[g][TYPE_MSB:TYPE_LSB];
            if (ivalid[g] && t != 3'd0) begin
                v = int'(ivch[g]);
                locked = (v <= VCH) ? m_olck[v] : 1'b0;
                m_odata = idata[g]; m_ovch = ivch[g]; m_ovalid = 1'b1;
                if (t == 3'd1 || t == 3'd3) begin
                    if (locked) m_err = 1'b1;
                end
                if (t == 3'd2 || t == 3'd4) begin
                    if (!locked) m_err = 1'b1;
                end
                if (v <= VCH && t == 3'd1) m_olck[v] = 1'b1;
                if (v <= VCH && t == 3'd2) m_olck[v] = 1'b0;
                if (v > VCH) m_err = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        #1;
        model_reset();
        chk("rst_grt", 64'(grt), 64'd0);
        check_outputs("rst");
        @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    initial begin
        idle();
        irdy = 2'b11; ilck = 2'b00;
        model_reset();
        @(negedge clk);

        // Reset asserted with live traffic on the link
        put(0, TYPE_HEAD, 0); put(3, TYPE_HEAD, 1);
        do_reset();
        cycle("after_rst");
        do_reset();

        // Single packet from inputc2 on VC 1
        idle(); irdy = 2'b01;
        put(2, TYPE_HEAD, 1); cycle("pkt_head");
        chk("pkt_olck_head", 64'(olck), 64'b10);
        put(2, TYPE_DATA, 1); cycle("pkt_data");
        put(2, TYPE_TAIL, 1); cycle("pkt_tail");
        chk("pkt_olck_tail", 64'(olck), 64'b00);
        chk("pkt_err", 64'(err), 64'd0);

        // Round-robin over inputs 0, 1 and 4, then input 4 alone
        idle(); irdy = 2'b10;
        for (int i = 0; i < 5; i++) port[i] = (PORTW + 1)'(P);
        req = 5'b10011;
        for (int n = 0; n < 6; n++) cycle("rr3");
        req = 5'b10000;
        for (int n = 0; n < 3; n++) cycle("rr4");

        // Port filter
        idle();
        put(3, TYPE_HEADTAIL, 0); port[3] = (PORTW + 1)'(P + 1);
        cycle("portf");
        chk("portf_ovalid", 64'(ovalid), 64'd0);

        // Single-flit packet
        idle(); put(1, TYPE_HEADTAIL, 0); cycle("ht");
        chk("ht_ovalid", 64'(ovalid), 64'd1);
        idle(); cycle("ht_idle");
        chk("ht_pulse", 64'(ovalid), 64'd0);
        chk("ht_err", 64'(err), 64'd0);

        // DATA on an unlocked VC sets a sticky error
        idle(); put(4, TYPE_DATA, 0); cycle("perr");
        chk("perr_err", 64'(err), 64'd1);
        idle(); cycle("perr_hold"); cycle("perr_hold");
        chk("perr_sticky", 64'(err), 64'd1);
        do_reset();

        // Randomized traffic with periodic resets
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 49) begin
                do_reset();
            end
            idle();
            irdy = 2'($urandom);
            ilck = 2'($urandom);
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    put(i, 3'($urandom_range(0, 4)),
                        ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1)));
                    if ($urandom_range(0, 5) == 0) port[i] = 3'($urandom_range(0, 4));
                    if ($urandom_range(0, 5) == 0) ivalid[i] = 1'b0;
                end
            end
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
